// File: rtl/heap_alloc_pkg.sv
// Shared types for the heap array allocator: FSM state and the request op encoding.
package heap_alloc_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_e;

   localparam logic OP_ALLOC = 1'b0;
   localparam logic OP_FREE  = 1'b1;

endpackage

// File: rtl/heap_array_allocator_rr_arbiter.sv
// Round-robin priority rotate: grants the first eligible requester after rr_i, with wrap.
module rr_arbiter
   import heap_alloc_pkg::*;
#(
   parameter int unsigned NReq = 4,
   localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1
) (
   input  logic [NReq-1:0] eligible_i,
   input  logic [IdxW-1:0] rr_i,
   output logic            grant_valid_o,
   output logic [IdxW-1:0] grant_idx_o
);

   int unsigned idx;

   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      idx           = 0;
      for (int unsigned k = 1; k <= NReq; k++) begin
         idx = (32'(rr_i) + k) % NReq;
         if (!grant_valid_o && eligible_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/heap_array_allocator.sv
// Serialises alloc/free requests from NReq requesters; owns the allocation counter and
// the LIFO stack of freed array indices, and clears arraySizes entries on allocation.
module heap_array_allocator
   import heap_alloc_pkg::*;
#(
   parameter int unsigned NReq               = 4,
   parameter int unsigned NArrays            = 20,
   parameter int unsigned NFreedArrays       = 20,
   parameter int unsigned MemoryElementWidth = 12
) (
   input  logic                               clock,
   input  logic                               reset_n,
   input  logic [NReq-1:0]                    req_valid,
   input  logic [NReq-1:0]                    req_free,
   input  logic [NReq*MemoryElementWidth-1:0] req_index,
   output logic [NReq-1:0]                    ack,
   output logic [MemoryElementWidth-1:0]      ack_index,
   output logic                               ack_error,
   output logic                               size_we,
   output logic [MemoryElementWidth-1:0]      size_addr,
   output logic [MemoryElementWidth-1:0]      size_data,
   output logic [MemoryElementWidth-1:0]      allocs,
   output logic [MemoryElementWidth-1:0]      free_count,
   output logic                               busy
);

   localparam int unsigned W    = MemoryElementWidth;
   localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1;
   localparam int unsigned SpW  = (NFreedArrays > 1) ? $clog2(NFreedArrays) : 1;

   state_e          state_q, state_d;
   logic [IdxW-1:0] rr_q, rr_d, win_q, win_d;
   logic            op_q, op_d;
   logic [W-1:0]    idx_q, idx_d;
   logic [NReq-1:0] ack_q, ack_d;
   logic [W-1:0]    ack_index_q, ack_index_d;
   logic            ack_error_q, ack_error_d;
   logic            size_we_q, size_we_d;
   logic [W-1:0]    size_addr_q, size_addr_d;
   logic [W-1:0]    allocs_q, allocs_d;
   logic [W-1:0]    free_count_q, free_count_d;
   logic [W-1:0]    stack_q [NFreedArrays];
   logic            push;

   logic            grant_valid;
   logic [IdxW-1:0] grant_idx;
   logic [SpW-1:0]  push_ptr, top_ptr;

   // The registered ack masks the just-served requester while its req is still high.
   rr_arbiter #(
      .NReq(NReq)
   ) u_arb (
      .eligible_i   (req_valid & ~ack_q),
      .rr_i         (rr_q),
      .grant_valid_o(grant_valid),
      .grant_idx_o  (grant_idx)
   );

   assign push_ptr = SpW'(free_count_q);
   assign top_ptr  = SpW'(free_count_q - 1'b1);

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      win_d        = win_q;
      op_d         = op_q;
      idx_d        = idx_q;
      ack_d        = '0;
      ack_index_d  = '0;
      ack_error_d  = 1'b0;
      size_we_d    = 1'b0;
      size_addr_d  = '0;
      allocs_d     = allocs_q;
      free_count_d = free_count_q;
      push         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               win_d   = grant_idx;
               rr_d    = grant_idx;
               op_d    = req_free[grant_idx];
               idx_d   = req_index[grant_idx*W +: W];
               state_d = SERVE;
            end
         end
         SERVE: begin
            state_d      = IDLE;
            ack_d[win_q] = 1'b1;
            if (op_q == OP_ALLOC) begin
               if (free_count_q != '0) begin
                  ack_index_d  = stack_q[top_ptr];
                  free_count_d = free_count_q - 1'b1;
                  size_we_d    = 1'b1;
                  size_addr_d  = stack_q[top_ptr];
               end else if (allocs_q < W'(NArrays)) begin
                  ack_index_d = allocs_q;
                  allocs_d    = allocs_q + 1'b1;
                  size_we_d   = 1'b1;
                  size_addr_d = allocs_q;
               end else begin
                  ack_error_d = 1'b1;
               end
            end else begin
               ack_index_d = idx_q;
               if (idx_q >= allocs_q || free_count_q == W'(NFreedArrays)) begin
                  ack_error_d = 1'b1;
               end else begin
                  push         = 1'b1;
                  free_count_d = free_count_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rr_q         <= IdxW'(NReq - 1);
         win_q        <= '0;
         op_q         <= OP_ALLOC;
         idx_q        <= '0;
         ack_q        <= '0;
         ack_index_q  <= '0;
         ack_error_q  <= 1'b0;
         size_we_q    <= 1'b0;
         size_addr_q  <= '0;
         allocs_q     <= '0;
         free_count_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         win_q        <= win_d;
         op_q         <= op_d;
         idx_q        <= idx_d;
         ack_q        <= ack_d;
         ack_index_q  <= ack_index_d;
         ack_error_q  <= ack_error_d;
         size_we_q    <= size_we_d;
         size_addr_q  <= size_addr_d;
         allocs_q     <= allocs_d;
         free_count_q <= free_count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         stack_q[push_ptr] <= idx_q;
      end
   end

   assign ack        = ack_q;
   assign ack_index  = ack_index_q;
   assign ack_error  = ack_error_q;
   assign size_we    = size_we_q;
   assign size_addr  = size_addr_q;
   assign size_data  = '0;
   assign allocs     = allocs_q;
   assign free_count = free_count_q;
   assign busy       = (state_q == SERVE);

endmodule

// File: tb/tb_heap_array_allocator.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_heap_array_allocator;

   localparam int NReq = 4;
   localparam int NArr = 20;
   localparam int NFrd = 20;
   localparam int W    = 12;

   logic            clock = 1'b0;
   logic            reset_n;
   logic [NReq-1:0] req_valid, req_free;
   logic [NReq*W-1:0] req_index;
   logic [NReq-1:0] ack;
   logic [W-1:0]    ack_index, size_addr, size_data, allocs, free_count;
   logic            ack_error, size_we, busy;

   heap_array_allocator #(
      .NReq(NReq), .NArrays(NArr), .NFreedArrays(NFrd), .MemoryElementWidth(W)
   ) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_free(req_free),
      .req_index(req_index), .ack(ack), .ack_index(ack_index), .ack_error(ack_error),
      .size_we(size_we), .size_addr(size_addr), .size_data(size_data), .allocs(allocs),
      .free_count(free_count), .busy(busy)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   bit        m_serving;
   int        m_rr, m_win, m_idx;
   bit        m_op;
   bit [NReq-1:0] m_ack;
   int        m_ack_index;
   bit        m_ack_error, m_size_we;
   int        m_size_addr;
   int        m_allocs;
   int        m_stk[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_serving = 0; m_rr = NReq - 1; m_win = 0; m_idx = 0; m_op = 0;
      m_ack = '0; m_ack_index = 0; m_ack_error = 0; m_size_we = 0; m_size_addr = 0;
      m_allocs = 0; m_stk.delete();
   endtask

   // One clock edge of the specified behaviour, evaluated from the inputs seen at the edge.
   task automatic model_step();
      bit [NReq-1:0] elig;
      if (!reset_n) begin
         model_reset();
         return;
      end
      elig = req_valid & ~m_ack;
      m_ack = '0; m_ack_error = 0; m_size_we = 0; m_ack_index = 0; m_size_addr = 0;
      if (!m_serving) begin
         for (int k = 1; k <= NReq; k++) begin
            int r;
            r = (m_rr + k) % NReq;
            if (elig[r]) begin
               m_win = r; m_rr = r; m_op = req_free[r]; m_idx = int'(req_index[r*W +: W]);
               m_serving = 1;
               break;
            end
         end
      end else begin
         m_serving = 0;
         m_ack[m_win] = 1'b1;
         if (!m_op) begin
            if (m_stk.size() > 0) begin
               m_ack_index = m_stk.pop_back();
               m_size_we = 1; m_size_addr = m_ack_index;
            end else if (m_allocs < NArr) begin
               m_ack_index = m_allocs; m_allocs++;
               m_size_we = 1; m_size_addr = m_ack_index;
            end else begin
               m_ack_error = 1;
            end
         end else begin
            m_ack_index = m_idx;
            if (m_idx >= m_allocs || m_stk.size() == NFrd) m_ack_error = 1;
            else m_stk.push_back(m_idx);
         end
      end
   endtask

   task automatic compare_all();
      check("ack", 32'(ack), 32'(m_ack));
      if (m_ack != 0) begin
         check("ack_index", 32'(ack_index), 32'(m_ack_index));
         check("ack_error", 32'(ack_error), 32'(m_ack_error));
      end
      check("size_we", 32'(size_we), 32'(m_size_we));
      if (m_size_we) check("size_addr", 32'(size_addr), 32'(m_size_addr));
      check("size_data", 32'(size_data), 0);
      check("allocs", 32'(allocs), 32'(m_allocs));
      check("free_count", 32'(free_count), 32'(m_stk.size()));
      check("busy", 32'(busy), 32'(m_serving));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare_all();
   endtask

   task automatic set_req(int r, bit f, int idx);
      req_valid[r] = 1'b1;
      req_free[r]  = f;
      req_index[r*W +: W] = W'(idx);
   endtask

   // Single op from one requester with hand-computed expectations at the fixed 2-edge latency.
   task automatic do_op(int r, bit f, int idx, int e_idx, bit e_err, bit e_we);
      set_req(r, f, idx);
      tick();
      check("busy_after_grant", 32'(busy), 1);
      tick();
      check("ack_literal", 32'(ack), 32'(1 << r));
      check("ack_index_literal", 32'(ack_index), 32'(e_idx));
      check("ack_error_literal", 32'(ack_error), 32'(e_err));
      check("size_we_literal", 32'(size_we), 32'(e_we));
      if (e_we) check("size_addr_literal", 32'(size_addr), 32'(e_idx));
      req_valid[r] = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      req_valid = '0;
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      reset_n = 1'b0; req_valid = '0; req_free = '0; req_index = '0;
      #1;
      model_reset();
      compare_all();
      check("rst_allocs", 32'(allocs), 0);
      check("rst_ack", 32'(ack), 0);
      @(negedge clock);
      do_reset();

      // Three allocs, then free 1 / realloc 1
      for (int i = 0; i < 3; i++) do_op(0, 0, 0, i, 0, 1);
      check("t1_allocs", 32'(allocs), 3);
      do_op(0, 1, 1, 1, 0, 0);
      check("t2_free_count", 32'(free_count), 1);
      do_op(0, 0, 0, 1, 0, 1);
      check("t2_free_count_after", 32'(free_count), 0);

      // All four requesters alloc together after reset
      do_reset();
      for (int r = 0; r < NReq; r++) set_req(r, 0, 0);
      for (int k = 0; k < NReq; k++) begin
         tick();
         tick();
         check("t3_grant_order", 32'(ack), 32'(1 << k));
         check("t3_index", 32'(ack_index), 32'(k));
         req_valid[k] = 1'b0;
      end
      tick();
      check("t3_allocs", 32'(allocs), 4);

      // Exhaust indices, then one more alloc and an out-of-range free
      for (int i = 4; i < NArr; i++) do_op(1, 0, 0, i, 0, 1);
      do_op(2, 0, 0, 0, 1, 0);
      check("t4_allocs_sat", 32'(allocs), 20);
      do_op(3, 1, 25, 25, 1, 0);

      // Fill the freed stack, then overflow it
      for (int i = 0; i < NFrd; i++) do_op(i % NReq, 1, i, i, 0, 0);
      check("t5_full", 32'(free_count), 20);
      do_op(0, 1, 5, 5, 1, 0);
      check("t5_still_full", 32'(free_count), 20);
      do_op(1, 0, 0, 19, 0, 1);

      // Reset while in SERVE
      set_req(0, 0, 0);
      tick();
      check("t6_in_serve", 32'(busy), 1);
      do_reset();
      check("t6_allocs", 32'(allocs), 0);
      check("t6_ack", 32'(ack), 0);
      do_op(0, 0, 0, 0, 0, 1);

      // Randomized traffic, model-checked every cycle
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int r = 0; r < NReq; r++) begin
            if (m_ack[r]) begin
               if ($urandom_range(0, 2) == 0) set_req(r, $urandom_range(0, 9) < 4,
                                                      $urandom_range(0, 23));
               else req_valid[r] = 1'b0;
            end else if (!req_valid[r] && $urandom_range(0, 3) == 0) begin
               set_req(r, $urandom_range(0, 9) < 4, $urandom_range(0, 23));
            end
         end
      end
      req_valid = '0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/heap_array_allocator.md
Name: heap_array_allocator

Overview:
- Shared controller for array allocation on the heap. It serialises alloc/free requests from NReq requesters, for example several instruction-execution lanes or a DMA helper.
- Owns the allocation counter (allocs) and the freed-arrays LIFO stack.
- Drives the arraySizes write port that clears an array's size on allocation.
- Round-robin arbitration; one operation completes every 2 cycles.

Parameters:
- NReq, 4, number of requesters (2..8).
- NArrays, 20, maximum number of distinct arrays; legal indices 0..NArrays-1.
- NFreedArrays, 20, depth of the freed-arrays stack.
- MemoryElementWidth, 12, width of array indices and size data.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NReq  per-requester request; held until that requester's ack.
- req_free  in  NReq  per-requester op: 1 = free, 0 = alloc.
- req_index  in  NReq*MemoryElementWidth  index to free, requester r at bits [r*W +: W]; ignored for alloc.
- ack  out  NReq  one-hot, one-cycle completion pulse.
- ack_index  out  MemoryElementWidth  allocated index, or the echoed freed index; valid with ack.
- ack_error  out  1  op failed; valid with ack.
- size_we  out  1  one-cycle write strobe into arraySizes.
- size_addr  out  MemoryElementWidth  arraySizes entry to write.
- size_data  out  MemoryElementWidth  always 0.
- allocs  out  MemoryElementWidth  count of indices ever handed out (high-water mark).
- free_count  out  MemoryElementWidth  current freed-stack depth.
- busy  out  1  high while in SERVE.

Behaviour:
Reset:
- Asynchronous on reset_n low. State IDLE; all outputs 0; rr pointer = NReq-1.
- Stack contents don't-care.
- Reset mid-operation abandons the latched request: no ack, no size write.

FSM states: IDLE, SERVE.
- IDLE: eligible = req_valid & ~ack.
- If eligible != 0, grant the first set bit searching from (rr+1) mod NReq upward with wrap.
- On grant, latch winner/op/index, set rr = winner, go SERVE. Otherwise stay in IDLE.
- SERVE: execute the op at the clock edge, pulse ack[winner] for exactly the next cycle, return to IDLE.
- ack is registered, so the ~ack mask stops the winner being re-granted while its req is still high.
- Request-to-ack latency is 2 edges. Sustained throughput is 1 op per 2 cycles.

Alloc:
- If free_count > 0: pop, returning the top entry (LIFO).
- Else if allocs < NArrays: return allocs, then increment allocs.
- Else: ack_error=1, ack_index=0, no state change.
- On success: size_we=1, size_addr=index, size_data=0, in the same cycle as ack.

Free:
- If index >= allocs: ack_error=1.
- Else if free_count == NFreedArrays: ack_error=1 (stack full); no push.
- Otherwise push the index. ack_index echoes the index.
- size_we stays 0. Double free is not detected.

Other rules:
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait, with fairness bounded to NReq-1 other grants.
- A requester must drop req_valid, or present a new op, in the cycle after its ack.
- All comparisons are unsigned. allocs and free_count saturate by construction and never wrap.

Decomposition:
- Package heap_alloc_pkg holds the state enum (IDLE, SERVE) and the op encoding constants (OP_ALLOC = 0, OP_FREE = 1).
- Sub-module rr_arbiter: parameter NReq; inputs eligible and rr; outputs grant_valid and grant_idx (combinational priority rotate).
- The stack and counters stay in the top module.

Test Plan:
1. Single requester, three allocs after reset → ack_index 0, 1, 2, each 2 cycles after request; size_we with size_addr 0/1/2; allocs=3.
2. Free 1 then alloc → free acks with no error and free_count=1; the next alloc returns 1 and free_count=0.
3. All 4 requesters assert alloc in the same cycle → grants in order 0, 1, 2, 3; indices 0..3; acks spaced 2 cycles apart; no requester granted twice.
4. 20 allocs, then a 21st → the 21st sees ack_error=1, ack_index=0, no size_we; free index 25 → ack_error=1.
5. Fill the stack with 20 frees (NFreedArrays=20), then one more free → ack_error=1 and free_count stays 20.
6. Assert reset_n low while in SERVE → no ack; after release all outputs are 0 and the next alloc returns 0.
